// File: rtl/popcnt_shift_seq.sv
// Sequential ones-count of a 127-bit signed word, CHUNK bits per cycle,
// then an arithmetic right shift of that word by the resulting count.
module popcnt_shift_seq #(
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [126:0] din,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [6:0]   count,
  output logic [126:0] dout
);

  localparam int N     = 128 / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [126:0]       word_q, word_d;
  logic [6:0]         acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         count_q, count_d;
  logic [126:0]       dout_q, dout_d;
  logic               done_q, done_d;

  logic [127:0]       padded;
  logic [CHUNK-1:0]   chunk_bits;
  logic [6:0]         chunk_ones;
  logic signed [126:0] shifted;

  // Bit 127 of the padded word is a constant 0 so the last chunk counts only real bits.
  always_comb begin
    padded     = {1'b0, word_q};
    chunk_bits = padded[int'(idx_q)*CHUNK +: CHUNK];
    chunk_ones = '0;
    for (int b = 0; b < CHUNK; b++) begin
      chunk_ones = chunk_ones + {6'd0, chunk_bits[b]};
    end
  end

  assign shifted = $signed(word_q) >>> acc_q;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous so it acts between edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_COUNT;
      ST_COUNT: if (idx_q == IDX_W'(N - 1)) state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; start while busy never reaches word_d.
  always_comb begin
    word_d  = word_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    count_d = count_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          word_d = din;
          acc_d  = '0;
          idx_d  = '0;
        end
      end
      ST_COUNT: begin
        acc_d = acc_q + chunk_ones;
        idx_d = idx_q + IDX_W'(1);
      end
      ST_SHIFT: begin
        count_d = acc_q;
        dout_d  = shifted;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  // Output decode: handshake flags come straight from the state register.
  always_comb begin
    ready = (state_q == ST_IDLE);
    busy  = (state_q != ST_IDLE);
  end

  assign done  = done_q;
  assign count = count_q;
  assign dout  = dout_q;

endmodule
